// File: rtl/octalram_frame_sequencer_if.sv
// Pixel-push and Octal RAM operator command bundle; master = sequencer side, slave = environment side.
// No timing of its own: plain wires shared by sequencer, operator and pixel source.
interface octalram_frame_sequencer_if;
  logic        iPix_Valid;
  logic [15:0] iPix_Data;
  logic        iFrame_Start;
  logic        oPix_Ready;
  logic [2:0]  oOp_Code;
  logic        iOp_Done;
  logic [31:0] oAddress;
  logic [15:0] oData;
  logic        oInit_Done;
  logic        oFrame_Done;
  logic        oOverflow;
  logic        oErr;

  modport master (
    input  iPix_Valid, iPix_Data, iFrame_Start, iOp_Done,
    output oPix_Ready, oOp_Code, oAddress, oData, oInit_Done, oFrame_Done, oOverflow, oErr
  );

  modport slave (
    output iPix_Valid, iPix_Data, iFrame_Start, iOp_Done,
    input  oPix_Ready, oOp_Code, oAddress, oData, oInit_Done, oFrame_Done, oOverflow, oErr
  );
endinterface

// File: rtl/octalram_frame_sequencer.sv
// Octal RAM bring-up (reset IC, write MR, read MR) then FIFO-buffered pixel sync-writes; IRSTORE_TEST_PATTERN_EN stores index ramp.
// Push-to-op latency 2 cycles from idle; oPix_Ready drops on full FIFO, watchdog error or before init; words offered when not ready are dropped.
module octalram_frame_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter logic [31:0] FRAME_BASE  = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic                          iClk,
  input logic                          iRst,
  octalram_frame_sequencer_if.master   bus
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [15:0]      dat;
  } pix_t;

  typedef enum logic [2:0] {S_RST, S_OP, S_GAP, S_IDLE, S_ERR} state_t;

  pix_t             mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, push, pop;
  logic [IDX_W-1:0] last_idx, push_idx;
  logic             start_pend, ovf_q;
  pix_t             push_ent, head;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d, op_q, op_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             init_q, init_d, err_q, err_d, fdone_q, fdone_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.oPix_Ready = init_q & ~fifo_full & ~err_q;
  assign push           = bus.iPix_Valid & bus.oPix_Ready;
  assign pop            = (state_q == S_IDLE) && !fifo_empty;
  assign head           = mem[rd_ptr[AW-1:0]];

  // A frame start (this cycle or latched earlier) forces the next pushed word to index 0.
  always_comb begin
    push_idx = '0;
    if (!(bus.iFrame_Start || start_pend) && last_idx != LAST_IDX)
      push_idx = last_idx + IDX_W'(1);
  end

`ifdef IRSTORE_TEST_PATTERN_EN
  assign push_ent = '{idx: push_idx, dat: 16'(push_idx)};
`else
  assign push_ent = '{idx: push_idx, dat: bus.iPix_Data};
`endif

  always_ff @(posedge iClk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  // last_idx resets to the final index so a first push without a frame start still lands on 0.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_idx   <= LAST_IDX;
      start_pend <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + (AW+1)'(1);
        last_idx   <= push_idx;
        start_pend <= 1'b0;
      end else if (bus.iFrame_Start) begin
        start_pend <= 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (bus.iPix_Valid && !bus.oPix_Ready && init_q)
        ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_d      = op_q;
    wdog_d    = wdog_q;
    init_d    = init_q;
    err_d     = err_q;
    fdone_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cur_idx_d = cur_idx_q;
    case (state_q)
      S_RST: begin
        state_d = S_OP;
        step_d  = 3'd1;
        op_d    = 3'd1;
        wdog_d  = '0;
      end
      S_OP: begin
        if (bus.iOp_Done) begin
          op_d    = 3'd0;
          wdog_d  = '0;
          state_d = S_GAP;
          if (step_q == 3'd4 && cur_idx_q == LAST_IDX)
            fdone_d = 1'b1;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          op_d    = 3'd0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      // One idle-code cycle lets the operator return its internal counter to zero.
      S_GAP: begin
        case (step_q)
          3'd1, 3'd2: begin
            step_d  = step_q + 3'd1;
            op_d    = step_q + 3'd1;
            state_d = S_OP;
          end
          3'd3: begin
            init_d  = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          addr_d    = FRAME_BASE + 32'(head.idx);
          data_d    = head.dat;
          cur_idx_d = head.idx;
          step_d    = 3'd4;
          op_d      = 3'd4;
          wdog_d    = '0;
          state_d   = S_OP;
        end
      end
      S_ERR:   op_d = 3'd0;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_RST;
      step_q    <= 3'd0;
      op_q      <= 3'd0;
      wdog_q    <= '0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
      fdone_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      op_q      <= op_d;
      wdog_q    <= wdog_d;
      init_q    <= init_d;
      err_q     <= err_d;
      fdone_q   <= fdone_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  assign bus.oOp_Code    = op_q;
  assign bus.oAddress    = addr_q;
  assign bus.oData       = data_q;
  assign bus.oInit_Done  = init_q;
  assign bus.oFrame_Done = fdone_q;
  assign bus.oOverflow   = ovf_q;
  assign bus.oErr        = err_q;

endmodule

// File: tb/tb_octalram_frame_sequencer.sv
// Directed bench for octalram_frame_sequencer: bring-up, addressing/wrap, frame start, stall/overflow, reset, watchdog.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_octalram_frame_sequencer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 iClk = ~iClk;

  octalram_frame_sequencer_if bus ();

  octalram_frame_sequencer #(
    .FIFO_DEPTH  (4),
    .FRAME_WORDS (4),
    .FRAME_BASE  (BASE),
    .TIMEOUT_CYC (100)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_code"},  32'(bus.oOp_Code), 32'd0);
    chk({tag, "_ready"}, 32'(bus.oPix_Ready), 32'd0);
    chk({tag, "_addr"},  bus.oAddress, 32'd0);
    chk({tag, "_data"},  32'(bus.oData), 32'd0);
    chk({tag, "_init"},  32'(bus.oInit_Done), 32'd0);
    chk({tag, "_fdone"}, 32'(bus.oFrame_Done), 32'd0);
    chk({tag, "_ovf"},   32'(bus.oOverflow), 32'd0);
    chk({tag, "_err"},   32'(bus.oErr), 32'd0);
  endtask

  // Operator answers in the 5th cycle of the op; ends in the gap cycle.
  task automatic op_cycle(input logic [2:0] code, input logic fd);
    for (int i = 0; i < 4; i++) begin
      chk("op_hold", 32'(bus.oOp_Code), 32'(code));
      chk("fdone_low", 32'(bus.oFrame_Done), 32'd0);
      tick();
    end
    bus.iOp_Done = 1'b1;
    tick();
    bus.iOp_Done = 1'b0;
    chk("gap_code", 32'(bus.oOp_Code), 32'd0);
    chk("gap_fdone", 32'(bus.oFrame_Done), 32'(fd));
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [15:0] dat, input logic fd);
    int k = 0;
    while (bus.oOp_Code == 3'd0 && k < 20) begin
      tick();
      k++;
    end
    chk("wr_code", 32'(bus.oOp_Code), 32'd4);
    chk("wr_addr", bus.oAddress, addr);
    chk("wr_data", 32'(bus.oData), 32'(dat));
    op_cycle(3'd4, fd);
  endtask

  task automatic push(input logic [15:0] d, input logic fs);
    chk("push_ready", 32'(bus.oPix_Ready), 32'd1);
    bus.iPix_Valid   = 1'b1;
    bus.iPix_Data    = d;
    bus.iFrame_Start = fs;
    tick();
    bus.iPix_Valid   = 1'b0;
    bus.iFrame_Start = 1'b0;
  endtask

  initial begin
    bus.iPix_Valid   = 1'b0;
    bus.iPix_Data    = 16'h0;
    bus.iFrame_Start = 1'b0;
    bus.iOp_Done     = 1'b0;

    // Reset state and bring-up sequence 1,2,3 with single idle gaps
    tick();
    tick();
    chk_reset_outs("rst");
    iRst = 1'b0;
    tick();
    chk("bringup_code1", 32'(bus.oOp_Code), 32'd1);
    op_cycle(3'd1, 1'b0);
    chk("init_early", 32'(bus.oInit_Done), 32'd0);
    tick();
    chk("bringup_code2", 32'(bus.oOp_Code), 32'd2);
    op_cycle(3'd2, 1'b0);
    tick();
    chk("bringup_code3", 32'(bus.oOp_Code), 32'd3);
    op_cycle(3'd3, 1'b0);
    tick();
    chk("idle_code", 32'(bus.oOp_Code), 32'd0);
    chk("init_done", 32'(bus.oInit_Done), 32'd1);
    chk("idle_ready", 32'(bus.oPix_Ready), 32'd1);

    // Frame start then two words: op 4 appears two cycles after the first push
    bus.iFrame_Start = 1'b1;
    tick();
    bus.iFrame_Start = 1'b0;
    push(16'hAAAA, 1'b0);
    push(16'hBBBB, 1'b0);
    chk("push_lat_code", 32'(bus.oOp_Code), 32'd4);
    serve_write(BASE + 32'd0, 16'hAAAA, 1'b0);
    serve_write(BASE + 32'd1, 16'hBBBB, 1'b0);

    // Index wrap at FRAME_WORDS=4, frame done after index 3
    push(16'hCCCC, 1'b0);
    push(16'hDDDD, 1'b0);
    push(16'hEEEE, 1'b0);
    push(16'hFFFF, 1'b0);
    serve_write(BASE + 32'd2, 16'hCCCC, 1'b0);
    serve_write(BASE + 32'd3, 16'hDDDD, 1'b1);
    serve_write(BASE + 32'd0, 16'hEEEE, 1'b0);
    serve_write(BASE + 32'd1, 16'hFFFF, 1'b0);

    // Pending frame start, then frame start in the same cycle as a push
    bus.iFrame_Start = 1'b1;
    tick();
    bus.iFrame_Start = 1'b0;
    push(16'h1234, 1'b0);
    serve_write(BASE + 32'd0, 16'h1234, 1'b0);
    push(16'h5555, 1'b0);
    push(16'h6666, 1'b1);
    serve_write(BASE + 32'd1, 16'h5555, 1'b0);
    serve_write(BASE + 32'd0, 16'h6666, 1'b0);

    // Stalled operator: one word held in the op, four buffered, then overflow
    tick();
    for (int i = 0; i < 5; i++)
      push(16'hA000 + 16'(i), 1'b0);
    chk("full_ready", 32'(bus.oPix_Ready), 32'd0);
    chk("ovf_before", 32'(bus.oOverflow), 32'd0);
    bus.iPix_Valid = 1'b1;
    bus.iPix_Data  = 16'hF00D;
    tick();
    bus.iPix_Valid = 1'b0;
    chk("ovf_set", 32'(bus.oOverflow), 32'd1);
    serve_write(BASE + 32'd1, 16'hA000, 1'b0);
    serve_write(BASE + 32'd2, 16'hA001, 1'b0);
    serve_write(BASE + 32'd3, 16'hA002, 1'b1);
    serve_write(BASE + 32'd0, 16'hA003, 1'b0);
    serve_write(BASE + 32'd1, 16'hA004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drained_code", 32'(bus.oOp_Code), 32'd0);
    end
    chk("ovf_sticky", 32'(bus.oOverflow), 32'd1);

    // Reset in the middle of a write
    push(16'h7777, 1'b0);
    tick();
    chk("pre_rst_code", 32'(bus.oOp_Code), 32'd4);
    chk("pre_rst_addr", bus.oAddress, BASE + 32'd2);
    iRst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    tick();
    iRst = 1'b0;
    tick();
    chk("reissue_code1", 32'(bus.oOp_Code), 32'd1);

    // Watchdog: no done for code 1
    for (int i = 0; i < 99; i++)
      tick();
    chk("pre_to_code", 32'(bus.oOp_Code), 32'd1);
    chk("pre_to_err", 32'(bus.oErr), 32'd0);
    tick();
    chk("to_err", 32'(bus.oErr), 32'd1);
    chk("to_code", 32'(bus.oOp_Code), 32'd0);
    bus.iOp_Done = 1'b1;
    tick();
    bus.iOp_Done   = 1'b0;
    bus.iPix_Valid = 1'b1;
    tick();
    bus.iPix_Valid = 1'b0;
    chk("err_ready", 32'(bus.oPix_Ready), 32'd0);
    chk("err_ovf", 32'(bus.oOverflow), 32'd0);
    chk("err_init", 32'(bus.oInit_Done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("err_code", 32'(bus.oOp_Code), 32'd0);
    end
    chk("err_sticky", 32'(bus.oErr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
